// File: rtl/wb_write_queue_if.sv
// Handshake/regfile-port bundle for wb_write_queue.
// WB_FWD_EN adds the forwarding lookup signals.
interface wb_write_queue_if #(parameter int DEPTH = 4);
  logic        alu_valid;
  logic        alu_ready;
  logic        alu_wb_en;
  logic        alu_is_call;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic [31:0] alu_pc;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_hold;
  logic        is_wb;
  logic [3:0]  wr_adr;
  logic [31:0] wr_data;
  logic [15:0] pending;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_adr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_wb_en, alu_is_call, alu_rd, alu_data, alu_pc,
    input  ld_valid, ld_rd, ld_data, wb_hold,
    output alu_ready, ld_ready, is_wb, wr_adr, wr_data, pending, count
`ifdef WB_FWD_EN
    , input fwd_adr, output fwd_hit, fwd_data
`endif
  );

  modport master (
    output alu_valid, alu_wb_en, alu_is_call, alu_rd, alu_data, alu_pc,
    output ld_valid, ld_rd, ld_data, wb_hold,
    input  alu_ready, ld_ready, is_wb, wr_adr, wr_data, pending, count
`ifdef WB_FWD_EN
    , output fwd_adr, input fwd_hit, fwd_data
`endif
  );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback queue: ALU/load results -> DEPTH-entry FIFO -> one regfile write per cycle.
// Optional WB_FWD_EN adds a youngest-match forwarding lookup over queued/presented writes.
module wb_write_queue #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] RA_ADR = 4'd15
) (
  input logic            clk,
  input logic            reset,
  wb_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  adr;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t         mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              is_wb_q;
  logic [3:0]        wr_adr_q;
  logic [31:0]       wr_data_q;

  logic      full, ld_acc, alu_acc, push, pop;
  wb_entry_t enq;

  // Readiness looks only at registered occupancy, so a pop never frees a slot same-cycle.
  assign full    = (cnt == CW'(DEPTH));
  assign ld_acc  = bus.ld_valid && !full;
  assign alu_acc = bus.alu_valid && !full && !bus.ld_valid;
  assign push    = ld_acc || (alu_acc && (bus.alu_is_call || bus.alu_wb_en));
  assign pop     = (cnt != '0) && !bus.wb_hold;

  always_comb begin
    enq = '0;
    if (ld_acc)                enq = '{adr: bus.ld_rd,  data: bus.ld_data};
    else if (bus.alu_is_call)  enq = '{adr: RA_ADR,     data: bus.alu_pc + 32'd4};
    else                       enq = '{adr: bus.alu_rd, data: bus.alu_data};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      vld       <= '0;
      is_wb_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      // Push and pop never share a slot: that needs count==0 or count==DEPTH.
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
        wr_adr_q    <= mem[rd_ptr].adr;
        wr_data_q   <= mem[rd_ptr].data;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      is_wb_q <= pop;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  logic [15:0] pend;
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend[mem[i].adr] = 1'b1;
    if (is_wb_q) pend[wr_adr_q] = 1'b1;
  end

  assign bus.ld_ready  = !full;
  assign bus.alu_ready = !full && !bus.ld_valid;
  assign bus.is_wb     = is_wb_q;
  assign bus.wr_adr    = wr_adr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.pending   = pend;
  assign bus.count     = cnt;

`ifdef WB_FWD_EN
  logic          hit;
  logic [31:0]   hit_data;
  logic [AW-1:0] idx;
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (is_wb_q && wr_adr_q == bus.fwd_adr) begin
      hit      = 1'b1;
      hit_data = wr_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (vld[idx] && mem[idx].adr == bus.fwd_adr) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end
  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = hit_data;
`endif
endmodule
